instr_sequencer: RTL and testbench

INSTR_SEQUENCER -- requirements
Module: instr_sequencer

---
 rtl/instr_sequencer_if.sv | 33 +++
 rtl/instr_sequencer.sv | 121 ++++++++++++
 tb/tb_instr_sequencer.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/instr_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : instr_sequencer_if
// Brief    : Instruction handshake / decoder-timestep bundle for
//            instr_sequencer. The sequencer is the slave; the instruction
//            source and decoder side is the master.
// Revision : 1.0 - initial release
// ============================================================================
interface instr_sequencer_if;
    logic       run;
    logic       instr_valid;
    logic [9:0] instr_in;
    logic       clr;
    logic       instr_ready;
    logic [1:0] T;
    logic [9:0] ir;
    logic       busy;
    logic       done;
    logic       illegal;
    logic       timeout;
    logic [7:0] retired_count;

    modport slave (
        input  run, instr_valid, instr_in, clr,
        output instr_ready, T, ir, busy, done, illegal, timeout, retired_count
    );

    modport master (
        output run, instr_valid, instr_in, clr,
        input  instr_ready, T, ir, busy, done, illegal, timeout, retired_count
    );
endinterface
`default_nettype wire

// File: rtl/instr_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : instr_sequencer
// Brief    : Three-state (IDLE/FETCH/EXEC) instruction sequencer. Captures an
//            instruction on handshake, rejects undefined encodings after
//            FETCH, steps the decoder timestep T through EXEC until clr or
//            a T=3 timeout, and counts retired instructions.
// Revision : 1.0 - initial release
// ============================================================================
module instr_sequencer (
    input  wire                  clk,
    input  wire                  reset,
    instr_sequencer_if.slave     bus
);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_FETCH = 2'd1;
    localparam logic [1:0] c_EXEC  = 2'd2;
    localparam logic [1:0] c_T_MAX = 2'd3;

    logic [1:0] r_state;
    logic [1:0] r_t;
    logic [9:0] r_ir;
    logic [7:0] r_count;
    logic       r_done;
    logic       r_illegal;
    logic       r_timeout;

    logic       w_ready;
    logic       w_accept;
    logic       w_illegal;

    // Ready is combinational so a new instruction can be taken in the very
    // cycle a completion pulse is shown.
    assign w_ready  = bus.run && (r_state == c_IDLE);
    assign w_accept = w_ready && bus.instr_valid;

    // Undefined encodings: opcode 01 entirely, and opcode 00 with a function
    // field above 1011. Opcodes 10 and 11 are always defined.
    assign w_illegal = (r_ir[9:8] == 2'b01) ||
                       ((r_ir[9:8] == 2'b00) && (r_ir[3:0] > 4'b1011));

    // State, timestep and completion pulses advance together.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= c_IDLE;
            r_t       <= 2'd0;
            r_done    <= 1'b0;
            r_illegal <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_done    <= 1'b0;
            r_illegal <= 1'b0;
            r_timeout <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    r_t <= 2'd0;
                    if (w_accept) begin
                        r_state <= c_FETCH;
                    end
                end
                c_FETCH: begin
                    if (w_illegal) begin
                        r_state   <= c_IDLE;
                        r_t       <= 2'd0;
                        r_illegal <= 1'b1;
                    end else begin
                        r_state <= c_EXEC;
                        r_t     <= 2'd1;
                    end
                end
                c_EXEC: begin
                    if (bus.clr) begin
                        r_state <= c_IDLE;
                        r_t     <= 2'd0;
                        r_done  <= 1'b1;
                    end else if (r_t == c_T_MAX) begin
                        r_state   <= c_IDLE;
                        r_t       <= 2'd0;
                        r_timeout <= 1'b1;
                    end else begin
                        r_t <= r_t + 2'd1;
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                    r_t     <= 2'd0;
                end
            endcase
        end
    end

    // Instruction register loads only on a handshake and otherwise holds.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ir <= 10'd0;
        end else if (w_accept) begin
            r_ir <= bus.instr_in;
        end
    end

    // Retired count advances only on a clr-terminated EXEC; wraps naturally.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= 8'd0;
        end else if ((r_state == c_EXEC) && bus.clr) begin
            r_count <= r_count + 8'd1;
        end
    end

    assign bus.instr_ready   = w_ready;
    assign bus.T             = r_t;
    assign bus.ir            = r_ir;
    assign bus.busy          = (r_state == c_FETCH) || (r_state == c_EXEC);
    assign bus.done          = r_done;
    assign bus.illegal       = r_illegal;
    assign bus.timeout       = r_timeout;
    assign bus.retired_count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_instr_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_sequencer
// Brief    : Directed self-checking bench for instr_sequencer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instr_sequencer;

    logic clk;
    logic reset;
    int   r_vectors;
    int   r_miscompares;

    instr_sequencer_if bus ();

    instr_sequencer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case the bench ever stalls
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check_val(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        r_vectors = r_vectors + 1;
        if (obs !== exp) begin
            r_miscompares = r_miscompares + 1;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; return 1 ns after the edge (inputs/outputs settle).
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full observable snapshot against expected values.
    task automatic check_all(input string tag, input logic busy, input logic [1:0] t,
                             input logic [9:0] ir, input logic [7:0] cnt,
                             input logic dn, input logic il, input logic to);
        check_val({tag, ".busy"},    16'(bus.busy),          16'(busy));
        check_val({tag, ".T"},       16'(bus.T),             16'(t));
        check_val({tag, ".ir"},      16'(bus.ir),            16'(ir));
        check_val({tag, ".count"},   16'(bus.retired_count), 16'(cnt));
        check_val({tag, ".done"},    16'(bus.done),          16'(dn));
        check_val({tag, ".illegal"}, 16'(bus.illegal),       16'(il));
        check_val({tag, ".timeout"}, 16'(bus.timeout),       16'(to));
    endtask

    initial begin
        r_vectors     = 0;
        r_miscompares = 0;
        reset           = 1'b1;
        bus.run         = 1'b1;
        bus.instr_valid = 1'b1;
        bus.instr_in    = 10'h3FF;
        bus.clr         = 1'b1;

        // Reset beats a concurrent handshake and clr
        tick();
        tick();
        check_all("reset", 1'b0, 2'd0, 10'h000, 8'd0, 1'b0, 1'b0, 1'b0);
        reset           = 1'b0;
        bus.instr_valid = 1'b0;
        bus.clr         = 1'b0;
        bus.run         = 1'b0;
        #1;
        check_val("ready_run_low", 16'(bus.instr_ready), 16'd0);

        // add 0x062, clr at T=3
        bus.run         = 1'b1;
        bus.instr_valid = 1'b1;
        bus.instr_in    = 10'h062;
        #1;
        check_val("ready_idle", 16'(bus.instr_ready), 16'd1);
        tick();
        bus.instr_valid = 1'b0;
        check_all("add.fetch", 1'b1, 2'd0, 10'h062, 8'd0, 1'b0, 1'b0, 1'b0);
        check_val("add.fetch.ready", 16'(bus.instr_ready), 16'd0);
        tick();
        check_all("add.t1", 1'b1, 2'd1, 10'h062, 8'd0, 1'b0, 1'b0, 1'b0);
        tick();
        check_val("add.t2", 16'(bus.T), 16'd2);
        tick();
        check_val("add.t3", 16'(bus.T), 16'd3);
        bus.clr = 1'b1;
        tick();
        bus.clr = 1'b0;
        check_all("add.done", 1'b0, 2'd0, 10'h062, 8'd1, 1'b1, 1'b0, 1'b0);
        tick();
        check_val("add.done_once", 16'(bus.done), 16'd0);

        // load 0x010, clr at T=1, second instruction held valid
        bus.instr_valid = 1'b1;
        bus.instr_in    = 10'h010;
        tick();
        bus.instr_in    = 10'h2C5;
        tick();
        check_all("load.t1", 1'b1, 2'd1, 10'h010, 8'd1, 1'b0, 1'b0, 1'b0);
        bus.clr = 1'b1;
        tick();
        bus.clr = 1'b0;
        check_all("load.done", 1'b0, 2'd0, 10'h010, 8'd2, 1'b1, 1'b0, 1'b0);
        check_val("b2b.ready", 16'(bus.instr_ready), 16'd1);
        tick();
        bus.instr_valid = 1'b0;
        check_all("b2b.fetch", 1'b1, 2'd0, 10'h2C5, 8'd2, 1'b0, 1'b0, 1'b0);

        // clr held low: timeout
        tick();
        check_val("to.t1", 16'(bus.T), 16'd1);
        tick();
        check_val("to.t2", 16'(bus.T), 16'd2);
        tick();
        check_val("to.t3", 16'(bus.T), 16'd3);
        tick();
        check_all("to.pulse", 1'b0, 2'd0, 10'h2C5, 8'd2, 1'b0, 1'b0, 1'b1);
        tick();
        check_val("to.once", 16'(bus.timeout), 16'd0);

        // illegal opcode 01
        bus.instr_valid = 1'b1;
        bus.instr_in    = 10'h100;
        tick();
        bus.instr_valid = 1'b0;
        check_all("ill1.fetch", 1'b1, 2'd0, 10'h100, 8'd2, 1'b0, 1'b0, 1'b0);
        tick();
        check_all("ill1.pulse", 1'b0, 2'd0, 10'h100, 8'd2, 1'b0, 1'b1, 1'b0);
        // accept in the illegal cycle: opcode 00 func 1100
        bus.instr_valid = 1'b1;
        bus.instr_in    = 10'h00C;
        tick();
        bus.instr_valid = 1'b0;
        check_all("ill2.fetch", 1'b1, 2'd0, 10'h00C, 8'd2, 1'b0, 1'b0, 1'b0);
        tick();
        check_all("ill2.pulse", 1'b0, 2'd0, 10'h00C, 8'd2, 1'b0, 1'b1, 1'b0);
        tick();
        check_val("ill2.once", 16'(bus.illegal), 16'd0);

        // func 1011 is the legal boundary; clr ignored during FETCH
        bus.instr_valid = 1'b1;
        bus.instr_in    = 10'h00B;
        bus.clr         = 1'b1;
        tick();
        bus.instr_valid = 1'b0;
        check_val("edge.fetch.busy", 16'(bus.busy), 16'd1);
        tick();
        check_all("edge.exec", 1'b1, 2'd1, 10'h00B, 8'd2, 1'b0, 1'b0, 1'b0);
        tick();
        bus.clr = 1'b0;
        check_all("edge.done", 1'b0, 2'd0, 10'h00B, 8'd3, 1'b1, 1'b0, 1'b0);

        // run falls mid-instruction
        bus.instr_valid = 1'b1;
        bus.instr_in    = 10'h3FF;
        tick();
        bus.run = 1'b0;
        tick();
        check_all("run.exec", 1'b1, 2'd1, 10'h3FF, 8'd3, 1'b0, 1'b0, 1'b0);
        bus.clr      = 1'b1;
        bus.instr_in = 10'h062;
        tick();
        bus.clr = 1'b0;
        check_all("run.done", 1'b0, 2'd0, 10'h3FF, 8'd4, 1'b1, 1'b0, 1'b0);
        check_val("run.ready_low", 16'(bus.instr_ready), 16'd0);
        tick();
        check_all("run.hold", 1'b0, 2'd0, 10'h3FF, 8'd4, 1'b0, 1'b0, 1'b0);
        bus.instr_valid = 1'b0;
        bus.run         = 1'b1;

        // subtract 0x063, reset at T=2 with clr
        bus.instr_valid = 1'b1;
        bus.instr_in    = 10'h063;
        tick();
        bus.instr_valid = 1'b0;
        tick();
        tick();
        check_val("sub.t2", 16'(bus.T), 16'd2);
        reset   = 1'b1;
        bus.clr = 1'b1;
        tick();
        reset   = 1'b0;
        bus.clr = 1'b0;
        check_all("sub.reset", 1'b0, 2'd0, 10'h000, 8'd0, 1'b0, 1'b0, 1'b0);
        tick();
        check_all("sub.after", 1'b0, 2'd0, 10'h000, 8'd0, 1'b0, 1'b0, 1'b0);

        // 256 retirements wrap the counter
        for (int i = 1; i <= 256; i++) begin
            bus.instr_valid = 1'b1;
            bus.instr_in    = 10'h010;
            tick();
            bus.instr_valid = 1'b0;
            tick();
            bus.clr = 1'b1;
            tick();
            bus.clr = 1'b0;
            if (i == 255) check_val("wrap.255", 16'(bus.retired_count), 16'd255);
            if (i == 256) check_val("wrap.0",   16'(bus.retired_count), 16'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", r_vectors, r_miscompares);
        $finish;
    end

endmodule
`default_nettype wire
